// File: rtl/mem_dma_pkg.sv
// Shared definitions for mem_dma: register map, CTRL bit positions and FSM state encodings.
package mem_dma_pkg;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  // Write side of CTRL
  localparam int CTRL_START = 0;
  localparam int CTRL_FILL  = 1;
  localparam int CTRL_ABORT = 2;
  // Read side of CTRL
  localparam int CTRL_BUSY  = 0;
  localparam int CTRL_DONE  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_GAP  = 2'd3
  } dma_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_dma.sv
// Single-channel DMA initiator on the valid/ready memory bus: word copy SRC->DST or
// constant fill of DST, configured through a 4-register CPU port.
module mem_dma
  import mem_dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_we,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_data,
  output logic [31:0] reg_q,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        done
);

  dma_state_e state, state_nxt, gap_next, gap_next_nxt;

  logic [31:0]          src_q, dst_q, buf_q;
  logic [1:0]           src_lo_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 fill_q, abort_q, done_sticky_q;
  logic                 finish, idle, handshake, ctrl_wr, start_req, abort_req, start_go;

  assign idle      = (state == ST_IDLE);
  assign handshake = mem_valid && mem_ready;
  assign ctrl_wr   = reg_we && (reg_addr == REG_CTRL);
  assign abort_req = ctrl_wr && reg_data[CTRL_ABORT];
  assign start_req = ctrl_wr && reg_data[CTRL_START] && !reg_data[CTRL_ABORT];
  assign start_go  = idle && start_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gap_next <= ST_IDLE;
    end else begin
      state    <= state_nxt;
      gap_next <= gap_next_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    gap_next_nxt = gap_next;
    finish       = 1'b0;
    mem_valid    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = 4'h0;
    case (state)
      ST_IDLE: begin
        if (start_go) begin
          if (len_q == '0) finish = 1'b1;
          else state_nxt = reg_data[CTRL_FILL] ? ST_WR : ST_RD;
        end
      end
      ST_RD: begin
        mem_valid = 1'b1;
        mem_addr  = src_q;
        if (handshake) begin
          state_nxt    = ST_GAP;
          gap_next_nxt = ST_WR;
        end
      end
      ST_WR: begin
        mem_valid = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = buf_q;
        mem_wstrb = 4'hF;
        if (handshake) begin
          state_nxt = ST_GAP;
          if (len_q == LEN_WIDTH'(1)) gap_next_nxt = ST_IDLE;
          else gap_next_nxt = fill_q ? ST_WR : ST_RD;
        end
      end
      ST_GAP: begin
        // A latched abort overrides whatever beat was queued up next.
        if (abort_q || abort_req || gap_next == ST_IDLE) begin
          state_nxt = ST_IDLE;
          finish    = 1'b1;
        end else begin
          state_nxt = gap_next;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q         <= '0;
      src_lo_q      <= '0;
      dst_q         <= '0;
      len_q         <= '0;
      buf_q         <= '0;
      fill_q        <= 1'b0;
      abort_q       <= 1'b0;
      done_sticky_q <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= finish;
      if (idle && reg_we) begin
        case (reg_addr)
          REG_SRC: begin
            src_q    <= word_align(reg_data);
            src_lo_q <= reg_data[1:0];
          end
          REG_DST: dst_q <= word_align(reg_data);
          REG_LEN: len_q <= reg_data[LEN_WIDTH-1:0];
          default: ;
        endcase
      end
      // The fill pattern keeps the full 32-bit value written to SRC, low bits included.
      if (start_go) begin
        fill_q        <= reg_data[CTRL_FILL];
        done_sticky_q <= 1'b0;
        buf_q         <= {src_q[31:2], src_lo_q};
      end
      if (abort_req && !idle) abort_q <= 1'b1;
      if (handshake && state == ST_RD) begin
        buf_q <= mem_rdata;
        src_q <= src_q + 32'd4;
      end
      if (handshake && state == ST_WR) begin
        dst_q <= dst_q + 32'd4;
        len_q <= len_q - LEN_WIDTH'(1);
      end
      if (finish) begin
        done_sticky_q <= 1'b1;
        abort_q       <= 1'b0;
      end
    end
  end

  always_comb begin
    reg_q = '0;
    case (reg_addr)
      REG_SRC: reg_q = src_q;
      REG_DST: reg_q = dst_q;
      REG_LEN: reg_q[LEN_WIDTH-1:0] = len_q;
      default: begin
        reg_q[CTRL_BUSY] = !idle;
        reg_q[CTRL_FILL] = fill_q;
        reg_q[CTRL_DONE] = done_sticky_q;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_dma.sv
// Self-checking bench for mem_dma: responder with programmable ready delay, a queue of
// expected bus beats derived from the transfer parameters, and directed scenarios.
module tb_mem_dma;
  import mem_dma_pkg::*;
  timeunit 1ns;
  timeprecision 100ps;

  logic        clk = 1'b0, rst_n = 1'b0, reg_we = 1'b0, mem_ready = 1'b0, done;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_data = '0, reg_q, mem_addr, mem_wdata, mem_rdata = '0;
  logic        mem_valid;
  logic [3:0]  mem_wstrb;

  mem_dma #(.LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_addr(reg_addr), .reg_data(reg_data),
    .reg_q(reg_q), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_beat;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_addrs[$];
  int checks = 0, errors = 0, cyc = 0;
  int rd_count, wr_count, done_count = 0, done_cyc = 0, first_valid_cyc, last_wr_cyc, done_base;
  int wait_cnt = 0, cur_delay = 0;
  bit hold_low = 0, rand_delay = 0, stray_en = 0;
  logic prev_valid, prev_hs, prev2_hs, prev_done, hs;
  logic [31:0] prev_addr, prev_wdata;
  logic [3:0]  prev_wstrb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE0000;
  endfunction

  // Expected beat list: per word a read (copy only) followed by a write of that word.
  task automatic plan(input logic [31:0] src, input logic [31:0] dst, input int len,
                      input bit fill, input logic [31:0] pattern);
    for (int i = 0; i < len; i++) begin
      logic [31:0] sa, da;
      sa = src + 32'(4 * i);
      da = dst + 32'(4 * i);
      if (!fill) exp_q.push_back('{wr: 1'b0, addr: sa, data: 32'h0});
      exp_q.push_back('{wr: 1'b1, addr: da, data: fill ? pattern : rd_word(sa)});
    end
  endtask

  // Responder: updates ready/rdata mid-cycle, after the DUT outputs have settled.
  always begin
    @(posedge clk);
    #3;
    if (!mem_valid) begin
      wait_cnt  = 0;
      mem_ready = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 32'h0;
    end else begin
      if (wait_cnt == 0) cur_delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
      mem_ready = !hold_low && (wait_cnt >= cur_delay);
      mem_rdata = rd_word(mem_addr);
      wait_cnt++;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0; prev_hs = 1'b0; prev2_hs = 1'b0; prev_done = 1'b0;
    end else begin
      hs = mem_valid && mem_ready;
      if (prev_valid && !prev_hs) begin
        check_output("hold_valid", 32'(mem_valid), 32'd1);
        check_output("hold_addr", mem_addr, prev_addr);
        check_output("hold_wdata", mem_wdata, prev_wdata);
        check_output("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
      end
      if (prev_hs) check_output("gap_low", 32'(mem_valid), 32'd0);
      if (prev2_hs && exp_q.size() > 0) check_output("gap_one", 32'(mem_valid), 32'd1);
      if (mem_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_beat", mem_addr, 32'hFFFFFFFF);
        end else begin
          mon_beat = exp_q.pop_front();
          check_output("beat_wstrb", 32'(mem_wstrb), mon_beat.wr ? 32'hF : 32'h0);
          check_output("beat_addr", mem_addr, mon_beat.addr);
          if (mon_beat.wr) check_output("beat_wdata", mem_wdata, mon_beat.data);
        end
        if (mem_wstrb == 4'hF) begin
          mem[mem_addr] = mem_wdata;
          wr_count++;
        end else begin
          rd_addrs.push_back(mem_addr);
          rd_count++;
        end
      end
      if (prev_done) check_output("done_pulse", 32'(done), 32'd0);
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      prev2_hs = prev_hs; prev_hs = hs; prev_valid = mem_valid; prev_done = done;
      prev_addr = mem_addr; prev_wdata = mem_wdata; prev_wstrb = mem_wstrb;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_data = d;
    last_wr_cyc = cyc;
    tick(1);
    reg_we = 1'b0;
  endtask

  task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #0.1;
    check_output(name, reg_q, exp);
  endtask

  task automatic begin_test();
    rd_count = 0; wr_count = 0; rd_addrs.delete(); first_valid_cyc = -1; done_base = done_count;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_count == done_base && n < bound) begin
      tick(1);
      n++;
    end
    tick(3);
  endtask

  initial begin
    int start_cyc, n;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    check_output("rst_valid", 32'(mem_valid), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_addr", mem_addr, 32'h0);
    check_output("rst_wstrb", 32'(mem_wstrb), 32'h0);
    check_output("rst_wdata", mem_wdata, 32'h0);
    chk_reg("rst_src", REG_SRC, 32'h0);
    chk_reg("rst_ctrl", REG_CTRL, 32'h0);

    // 1: plain copy, zero-wait responder
    apply_stimulus(REG_SRC, 32'h1000); apply_stimulus(REG_DST, 32'h2000); apply_stimulus(REG_LEN, 32'd4);
    plan(32'h1000, 32'h2000, 4, 1'b0, 32'h0);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h1); start_cyc = last_wr_cyc;
    wait_done(100);
    check_output("t1_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t1_done_lat", 32'(done_cyc - start_cyc), 32'd17);
    check_output("t1_first_valid", 32'(first_valid_cyc - start_cyc), 32'd1);
    check_output("t1_reads", 32'(rd_count), 32'd4);
    check_output("t1_writes", 32'(wr_count), 32'd4);
    check_output("t1_exp_left", 32'(exp_q.size()), 32'd0);
    check_output("t1_mem_200c", rd_word(32'h200C), 32'hC0DE100C);
    chk_reg("t1_src", REG_SRC, 32'h1010);
    chk_reg("t1_dst", REG_DST, 32'h2010);
    chk_reg("t1_len", REG_LEN, 32'h0);
    chk_reg("t1_ctrl", REG_CTRL, 32'h4);

    // 2: fill mode
    apply_stimulus(REG_SRC, 32'hDEADBEEF); apply_stimulus(REG_DST, 32'h2100); apply_stimulus(REG_LEN, 32'd3);
    plan(32'h0, 32'h2100, 3, 1'b1, 32'hDEADBEEF);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h3); start_cyc = last_wr_cyc;
    wait_done(100);
    check_output("t2_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t2_done_lat", 32'(done_cyc - start_cyc), 32'd7);
    check_output("t2_reads", 32'(rd_count), 32'd0);
    check_output("t2_writes", 32'(wr_count), 32'd3);
    check_output("t2_exp_left", 32'(exp_q.size()), 32'd0);
    check_output("t2_mem_2108", rd_word(32'h2108), 32'hDEADBEEF);
    chk_reg("t2_src", REG_SRC, 32'hDEADBEEC);
    chk_reg("t2_ctrl", REG_CTRL, 32'h6);

    // 3: zero length
    apply_stimulus(REG_LEN, 32'd0);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h1); start_cyc = last_wr_cyc;
    wait_done(10);
    check_output("t3_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t3_done_lat", 32'(done_cyc - start_cyc), 32'd1);
    check_output("t3_no_valid", 32'(first_valid_cyc), 32'hFFFFFFFF);
    chk_reg("t3_ctrl", REG_CTRL, 32'h4);

    // 4: random ready delay, stray ready, config writes and restart while busy
    rand_delay = 1; stray_en = 1;
    apply_stimulus(REG_SRC, 32'h4000); apply_stimulus(REG_DST, 32'h4800); apply_stimulus(REG_LEN, 32'd8);
    plan(32'h4000, 32'h4800, 8, 1'b0, 32'h0);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h1);
    tick(6);
    chk_reg("t4_busy", REG_CTRL, 32'h1);
    apply_stimulus(REG_SRC, 32'h55550000);
    apply_stimulus(REG_CTRL, 32'h1);
    wait_done(400);
    rand_delay = 0; stray_en = 0;
    check_output("t4_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t4_reads", 32'(rd_count), 32'd8);
    check_output("t4_writes", 32'(wr_count), 32'd8);
    check_output("t4_exp_left", 32'(exp_q.size()), 32'd0);
    chk_reg("t4_src", REG_SRC, 32'h4020);
    chk_reg("t4_dst", REG_DST, 32'h4820);
    chk_reg("t4_len", REG_LEN, 32'h0);

    // 5: abort while the first read is stalled for 5 cycles
    apply_stimulus(REG_SRC, 32'h6000); apply_stimulus(REG_DST, 32'h7000); apply_stimulus(REG_LEN, 32'd3);
    plan(32'h6000, 32'h7000, 3, 1'b0, 32'h0);
    begin_test();
    hold_low = 1;
    apply_stimulus(REG_CTRL, 32'h1);
    tick(1);
    apply_stimulus(REG_CTRL, 32'h4);
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    tick(3);
    hold_low = 0;
    wait_done(50);
    check_output("t5_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t5_reads", 32'(rd_count), 32'd1);
    check_output("t5_writes", 32'(wr_count), 32'd0);
    check_output("t5_exp_left", 32'(exp_q.size()), 32'd0);
    chk_reg("t5_len", REG_LEN, 32'd3);
    chk_reg("t5_src", REG_SRC, 32'h6004);
    chk_reg("t5_dst", REG_DST, 32'h7000);
    chk_reg("t5_ctrl", REG_CTRL, 32'h4);

    // 6: reset during a write beat, then source address wrap
    apply_stimulus(REG_SRC, 32'h8000); apply_stimulus(REG_DST, 32'h9000); apply_stimulus(REG_LEN, 32'd4);
    plan(32'h8000, 32'h9000, 4, 1'b0, 32'h0);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h1);
    n = 0;
    while (!(mem_valid && mem_wstrb == 4'hF) && n < 40) begin
      tick(1);
      n++;
    end
    check_output("t6_saw_write", 32'(mem_valid && mem_wstrb == 4'hF), 32'd1);
    hold_low = 1;
    rst_n = 1'b0;
    #0.1;
    check_output("t6_rst_valid", 32'(mem_valid), 32'd0);
    check_output("t6_rst_addr", mem_addr, 32'h0);
    exp_q.delete();
    tick(2);
    hold_low = 0;
    rst_n = 1'b1;
    tick(1);
    chk_reg("t6_src0", REG_SRC, 32'h0);
    chk_reg("t6_dst0", REG_DST, 32'h0);
    chk_reg("t6_len0", REG_LEN, 32'h0);
    chk_reg("t6_ctrl0", REG_CTRL, 32'h0);
    apply_stimulus(REG_SRC, 32'hFFFFFFFC); apply_stimulus(REG_DST, 32'h3000); apply_stimulus(REG_LEN, 32'd2);
    plan(32'hFFFFFFFC, 32'h3000, 2, 1'b0, 32'h0);
    begin_test();
    apply_stimulus(REG_CTRL, 32'h1);
    wait_done(100);
    check_output("t6_done_once", 32'(done_count - done_base), 32'd1);
    check_output("t6_reads", 32'(rd_count), 32'd2);
    check_output("t6_exp_left", 32'(exp_q.size()), 32'd0);
    check_output("t6_rd2_addr", (rd_addrs.size() > 1) ? rd_addrs[1] : 32'hDEAD0001, 32'h0);
    check_output("t6_mem_3004", rd_word(32'h3004), 32'hC0DE0000);
    chk_reg("t6_src_wrap", REG_SRC, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
